// File: rtl/scene1_index_fetch_if.sv
// Pixel-side bundle for the scene-1 index fetcher: raster coords in, ROM port, palette index out.
// Latency: none (wiring only).
// Backpressure: none; the raster never stalls, one pixel per clock.
//
// Signals: frame_start/cam_x (camera control), DrawX/DrawY/de (raster),
// rom_addr/rom_q (background ROM), index/index_valid (to palette), cam_q (camera in use).
// slave = fetcher side, master = raster/ROM/palette side.
interface scene1_index_fetch_if #(
    parameter int unsigned ADDR_W = 17
);
    logic              frame_start;
    logic [9:0]        cam_x;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              de;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_q;
    logic [3:0]        index;
    logic              index_valid;
    logic [9:0]        cam_q;

    modport slave (
        input  frame_start, cam_x, DrawX, DrawY, de, rom_q,
        output rom_addr, index, index_valid, cam_q
    );

    modport master (
        output frame_start, cam_x, DrawX, DrawY, de, rom_q,
        input  rom_addr, index, index_valid, cam_q
    );
endinterface

// File: rtl/scene1_index_fetch.sv
// Maps raster coords plus a panning camera offset to a scene-1 ROM address and palette index.
// Latency: 3 cycles DrawX/DrawY/de -> index/index_valid; rom_addr registered 1 cycle after coords.
// Backpressure: none; fully pipelined, accepts one pixel every clock.
//
// Ports: Clk, Reset (sync, active-high); bus (slave modport) carries frame_start, cam_x,
// DrawX, DrawY, de, rom_q in and rom_addr, index, index_valid, cam_q out.
// Optional feature: define SCENE1_WRAP_EN to tile the background horizontally; camera may then
// range over the full scene width and source X wraps around instead of being clamped.
module scene1_index_fetch #(
    parameter int unsigned SCENE_W     = 384,
    parameter int unsigned SCENE_H     = 240,
    parameter int unsigned SCALE_SH    = 1,
    parameter int unsigned VIS_W       = 640,
    parameter int unsigned PAN_STEP    = 4,
    parameter int unsigned ADDR_W      = 17,
    parameter logic [3:0]  BLANK_INDEX = 4'h8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    scene1_index_fetch_if.slave   bus
);

`ifdef SCENE1_WRAP_EN
    localparam int unsigned CAM_MAX = SCENE_W - 1;
`else
    // Right edge of the visible window stops at the right edge of the scene.
    localparam int unsigned CAM_MAX = SCENE_W - (VIS_W >> SCALE_SH);
`endif

    logic [9:0]        cam_r;
    logic [9:0]        tgt;
    logic [10:0]       cam_plus;
    logic [10:0]       tgt_plus;

    logic [10:0]       sx_raw;
    logic [10:0]       sx;
    logic [9:0]        sy;
    logic              in_range;
    logic [ADDR_W-1:0] addr_calc;

    logic [ADDR_W-1:0] addr_r;
    logic              v1;
    logic              v2;
    logic [3:0]        idx_r;
    logic              vld_r;

    // Camera target and pan comparisons; 11-bit sums so cam+step never wraps.
    always_comb begin
        tgt      = (bus.cam_x > 10'(CAM_MAX)) ? 10'(CAM_MAX) : bus.cam_x;
        cam_plus = {1'b0, cam_r} + 11'(PAN_STEP);
        tgt_plus = {1'b0, tgt}   + 11'(PAN_STEP);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cam_r <= '0;
        end else if (bus.frame_start) begin
            if ({1'b0, tgt} > cam_plus)
                cam_r <= cam_r + 10'(PAN_STEP);
            else if (tgt_plus < {1'b0, cam_r})
                cam_r <= cam_r - 10'(PAN_STEP);
            else
                cam_r <= tgt;
        end
    end

    // Stage 1 address generation uses the camera value from before any same-cycle update.
    always_comb begin
        sx_raw = 11'(bus.DrawX >> SCALE_SH) + {1'b0, cam_r};
`ifdef SCENE1_WRAP_EN
        sx = (sx_raw >= 11'(SCENE_W)) ? (sx_raw - 11'(SCENE_W)) : sx_raw;
`else
        sx = sx_raw;
`endif
        sy        = bus.DrawY >> SCALE_SH;
        in_range  = bus.de && (sy < 10'(SCENE_H)) && (sx < 11'(SCENE_W));
        addr_calc = ADDR_W'(sy) * ADDR_W'(SCENE_W) + ADDR_W'(sx);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_r <= '0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            idx_r  <= BLANK_INDEX;
            vld_r  <= 1'b0;
        end else begin
            // Out-of-range address is parked at 0; its ROM data is discarded at stage 3.
            addr_r <= in_range ? addr_calc : '0;
            v1     <= in_range;
            v2     <= v1;
            idx_r  <= v2 ? bus.rom_q : BLANK_INDEX;
            vld_r  <= v2;
        end
    end

    assign bus.rom_addr    = addr_r;
    assign bus.index       = idx_r;
    assign bus.index_valid = vld_r;
    assign bus.cam_q       = cam_r;

endmodule

// File: tb/tb_scene1_index_fetch.sv
// Self-checking bench for scene1_index_fetch against a plain-arithmetic pixel/camera model.
// Latency: n/a (bench); ROM model returns addr[3:0] one cycle after rom_addr.
// Backpressure: n/a; stimulus is one pixel per clock.
module tb_scene1_index_fetch;

    localparam int SCENE_W  = 384;
    localparam int SCENE_H  = 240;
    localparam int SCALE_SH = 1;
    localparam int VIS_W    = 640;
    localparam int PAN_STEP = 4;
    localparam int BLANK    = 8;
`ifdef SCENE1_WRAP_EN
    localparam int CAM_MAX  = SCENE_W - 1;
`else
    localparam int CAM_MAX  = SCENE_W - (VIS_W >> SCALE_SH);
`endif

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    scene1_index_fetch_if #(.ADDR_W(17)) bus ();

    scene1_index_fetch dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Synchronous ROM: content is the low nibble of the address.
    always @(posedge Clk) bus.rom_q <= bus.rom_addr[3:0];

    int checks = 0;
    int errors = 0;
    int model_cam = 0;

    function automatic int cam_next(input int cam, input int req);
        int t;
        t = (req > CAM_MAX) ? CAM_MAX : req;
        if (t > cam + PAN_STEP) return cam + PAN_STEP;
        if (t + PAN_STEP < cam) return cam - PAN_STEP;
        return t;
    endfunction

    function automatic void pixel_model(input int cam, input int x, input int y, input bit de,
                                        output int addr, output bit vld);
        int sx, sy;
        sx = (x >> SCALE_SH) + cam;
`ifdef SCENE1_WRAP_EN
        if (sx >= SCENE_W) sx = sx - SCENE_W;
`endif
        sy   = y >> SCALE_SH;
        vld  = de && (sy < SCENE_H) && (sx < SCENE_W);
        addr = vld ? (sy * SCENE_W + sx) : 0;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame_pulse(input int req);
        bus.cam_x       = 10'(req);
        bus.frame_start = 1'b1;
        bus.de          = 1'b0;
        tick();
        bus.frame_start = 1'b0;
        model_cam       = cam_next(model_cam, req);
    endtask

    task automatic test_reset();
        Reset           = 1'b1;
        bus.frame_start = 1'b0;
        bus.cam_x       = 10'd0;
        bus.DrawX       = 10'd10;
        bus.DrawY       = 10'd6;
        bus.de          = 1'b1;
        tick();
        tick();
        model_cam = 0;
        checks++; if (bus.index !== 4'(BLANK)) begin errors++; $display("FAIL reset_index got %0d want %0d", bus.index, BLANK); end
        checks++; if (bus.index_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.index_valid); end
        checks++; if (bus.cam_q !== 10'd0) begin errors++; $display("FAIL reset_cam got %0d want 0", bus.cam_q); end
        checks++; if (bus.rom_addr !== 17'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", bus.rom_addr); end
        Reset  = 1'b0;
        bus.de = 1'b0;
    endtask

    task automatic test_pixel();
        bus.DrawX = 10'd10;
        bus.DrawY = 10'd6;
        bus.de    = 1'b1;
        tick();
        bus.de = 1'b0;
        checks++; if (bus.rom_addr !== 17'd1157) begin errors++; $display("FAIL pixel_addr got %0d want 1157", bus.rom_addr); end
        tick();
        tick();
        checks++; if (bus.index !== 4'd5) begin errors++; $display("FAIL pixel_index got %0d want 5", bus.index); end
        checks++; if (bus.index_valid !== 1'b1) begin errors++; $display("FAIL pixel_valid got %0b want 1", bus.index_valid); end
    endtask

    task automatic test_blank();
        bus.DrawX = 10'd10;
        bus.DrawY = 10'd6;
        bus.de    = 1'b0;
        tick(); tick(); tick();
        checks++; if (bus.index !== 4'(BLANK) || bus.index_valid !== 1'b0) begin
            errors++; $display("FAIL blank_de0 got %0d/%0b want %0d/0", bus.index, bus.index_valid, BLANK); end
        bus.DrawY = 10'd480;
        bus.de    = 1'b1;
        tick(); tick(); tick();
        checks++; if (bus.index !== 4'(BLANK) || bus.index_valid !== 1'b0) begin
            errors++; $display("FAIL blank_row240 got %0d/%0b want %0d/0", bus.index, bus.index_valid, BLANK); end
        bus.de = 1'b0;
    endtask

    task automatic test_pan();
        for (int f = 1; f <= 12; f++) begin
            frame_pulse(40);
            if (f == 5) begin
                checks++; if (bus.cam_q !== 10'd20) begin errors++; $display("FAIL pan_5 got %0d want 20", bus.cam_q); end
            end
            if (f == 10 || f == 12) begin
                checks++; if (bus.cam_q !== 10'd40) begin errors++; $display("FAIL pan_%0d got %0d want 40", f, bus.cam_q); end
            end
        end
    endtask

    task automatic test_saturate();
        int a; bit v;
        for (int f = 0; f < 50; f++) frame_pulse(200);
        checks++; if (int'(bus.cam_q) !== model_cam) begin errors++; $display("FAIL sat_cam got %0d want %0d", bus.cam_q, model_cam); end
`ifndef SCENE1_WRAP_EN
        checks++; if (bus.cam_q !== 10'd64) begin errors++; $display("FAIL sat_cam64 got %0d want 64", bus.cam_q); end
`endif
        pixel_model(model_cam, 639, 0, 1'b1, a, v);
        bus.DrawX = 10'd639;
        bus.DrawY = 10'd0;
        bus.de    = 1'b1;
        tick();
        bus.de = 1'b0;
        checks++; if (int'(bus.rom_addr) !== a) begin errors++; $display("FAIL sat_edge_addr got %0d want %0d", bus.rom_addr, a); end
    endtask

    task automatic test_back_to_back();
        int q_addr[$];
        bit q_vld[$];
        int a, x, y, ea;
        bit v, d, ev, fs;
        for (int i = 0; i < 600; i++) begin
            x  = $urandom_range(0, 767);
            y  = $urandom_range(0, 520);
            d  = ($urandom_range(0, 7) != 0);
            fs = ($urandom_range(0, 19) == 0);
            bus.DrawX       = 10'(x);
            bus.DrawY       = 10'(y);
            bus.de          = d;
            bus.frame_start = fs;
            bus.cam_x       = 10'($urandom_range(0, 1023));
            pixel_model(model_cam, x, y, d, a, v);
            q_addr.push_back(a);
            q_vld.push_back(v);
            if (fs) model_cam = cam_next(model_cam, int'(bus.cam_x));
            tick();
            checks++; if (int'(bus.rom_addr) !== a) begin errors++; $display("FAIL b2b_addr cyc %0d got %0d want %0d", i, bus.rom_addr, a); end
            checks++; if (int'(bus.cam_q) !== model_cam) begin errors++; $display("FAIL b2b_cam cyc %0d got %0d want %0d", i, bus.cam_q, model_cam); end
            if (q_addr.size() == 3) begin
                ea = q_addr.pop_front();
                ev = q_vld.pop_front();
                checks++; if (bus.index_valid !== ev || int'(bus.index) !== (ev ? (ea % 16) : BLANK)) begin
                    errors++; $display("FAIL b2b_index cyc %0d got %0d/%0b want %0d/%0b", i, bus.index, bus.index_valid,
                                       ev ? (ea % 16) : BLANK, ev); end
            end
        end
        bus.frame_start = 1'b0;
        bus.de          = 1'b0;
    endtask

`ifdef SCENE1_WRAP_EN
    task automatic test_wrap();
        for (int f = 0; f < 110; f++) frame_pulse(380);
        checks++; if (bus.cam_q !== 10'd380) begin errors++; $display("FAIL wrap_cam got %0d want 380", bus.cam_q); end
        bus.DrawX = 10'd20;
        bus.DrawY = 10'd0;
        bus.de    = 1'b1;
        tick();
        bus.de = 1'b0;
        checks++; if (bus.rom_addr !== 17'd6) begin errors++; $display("FAIL wrap_addr got %0d want 6", bus.rom_addr); end
    endtask
`endif

    task automatic test_reset_midline();
        int a; bit v;
        for (int f = 0; f < 12; f++) frame_pulse(40);
        bus.DrawX = 10'd20;
        bus.DrawY = 10'd10;
        bus.de    = 1'b1;
        tick(); tick(); tick();
        checks++; if (bus.index_valid !== 1'b1) begin errors++; $display("FAIL midline_pre_valid got %0b want 1", bus.index_valid); end
        Reset = 1'b1;
        tick();
        Reset     = 1'b0;
        model_cam = 0;
        checks++; if (bus.index !== 4'(BLANK) || bus.index_valid !== 1'b0) begin
            errors++; $display("FAIL midline_blank0 got %0d/%0b want %0d/0", bus.index, bus.index_valid, BLANK); end
        checks++; if (bus.cam_q !== 10'd0) begin errors++; $display("FAIL midline_cam got %0d want 0", bus.cam_q); end
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++; if (bus.index !== 4'(BLANK) || bus.index_valid !== 1'b0) begin
                errors++; $display("FAIL midline_blank%0d got %0d/%0b want %0d/0", k, bus.index, bus.index_valid, BLANK); end
        end
        pixel_model(0, 20, 10, 1'b1, a, v);
        tick();
        checks++; if (bus.index_valid !== v || int'(bus.index) !== (a % 16)) begin
            errors++; $display("FAIL midline_resume got %0d/%0b want %0d/%0b", bus.index, bus.index_valid, a % 16, v); end
        bus.de = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pixel();
        test_blank();
        test_pan();
        test_saturate();
        test_back_to_back();
`ifdef SCENE1_WRAP_EN
        test_wrap();
`endif
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
